// File: rtl/bsg_manycore_pkg.sv
// Shared definitions for the manycore store protocol.
// Contents: op encodings, a reference packet layout, and a small op-decode helper.
// Used by the packet receiver here and by the packet encoder on the send side.
package bsg_manycore_pkg;

  localparam int op_width_gp = 6;

  // Op encodings. Only remote stores are executed by the receive endpoint.
  localparam logic [op_width_gp-1:0] op_remote_store = 6'd1;

  // Reference coordinate/payload widths of the standard tile configuration.
  localparam int ref_x_cord_width_gp = 4;
  localparam int ref_y_cord_width_gp = 4;
  localparam int ref_data_width_gp   = 32;
  localparam int ref_addr_width_gp   = 12;

  // Packet layout, MSB to LSB. Parameterized blocks declare an identically
  // ordered struct with their own field widths.
  typedef struct packed {
    logic [op_width_gp-1:0]         op;
    logic [ref_addr_width_gp-1:0]   addr;
    logic [ref_data_width_gp-1:0]   data;
    logic [ref_y_cord_width_gp-1:0] from_y;
    logic [ref_x_cord_width_gp-1:0] from_x;
    logic [ref_y_cord_width_gp-1:0] y;
    logic [ref_x_cord_width_gp-1:0] x;
  } bsg_manycore_packet_s;

  function automatic logic is_remote_store(input logic [op_width_gp-1:0] op);
    return op == op_remote_store;
  endfunction

endpackage

// File: rtl/bsg_manycore_pkt_fifo.sv
// Packet input buffer: circular FIFO of els_p entries (legal 2..8), no bypass.
// Ports: v_i/data_i/ready_o enqueue side; v_o/data_o/yumi_i dequeue side.
// ready_o comes only from the registered count, so no enqueue happens while
// full even when the head is being consumed in the same cycle.
module bsg_manycore_pkt_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] rptr_r, wptr_r;
  // Explicit occupancy count: rptr_r == wptr_r alone cannot tell full from empty.
  logic [cnt_width_lp-1:0] count_r;
  logic                    enq, deq;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign ready_o = (count_r != cnt_width_lp'(els_p));
  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= ptr_inc(wptr_r);
      if (deq) rptr_r <= ptr_inc(rptr_r);
      case ({enq, deq})
        2'b10:   count_r <= count_r + cnt_width_lp'(1);
        2'b01:   count_r <= count_r - cnt_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed when count_r says so.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_pkt_receive.sv
// Network-side endpoint: buffers packets, executes local remote stores, drops the rest.
// Ports: router side v_i/data_i/ready_o; memory side v_o/we_o/addr_o/data_o/mask_o/yumi_i;
// status credit_v_o (per store), drop_v_o (per drop), drop_cnt_o (saturating).
module bsg_manycore_pkt_receive
  import bsg_manycore_pkg::*;
#(
  parameter int x_cord_width_p   = 4,
  parameter int y_cord_width_p   = 4,
  parameter int data_width_p     = 32,
  parameter int addr_width_p     = 12,
  parameter int fifo_els_p       = 2,
  parameter int drop_cnt_width_p = 8,
  localparam int packet_width_lp = 6 + 2*x_cord_width_p + 2*y_cord_width_p
                                   + data_width_p + addr_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [x_cord_width_p-1:0]   my_x_i,
  input  logic [y_cord_width_p-1:0]   my_y_i,
  input  logic                        v_i,
  input  logic [packet_width_lp-1:0]  data_i,
  output logic                        ready_o,
  output logic                        v_o,
  output logic                        we_o,
  output logic [addr_width_p-1:0]     addr_o,
  output logic [data_width_p-1:0]     data_o,
  output logic [data_width_p/8-1:0]   mask_o,
  input  logic                        yumi_i,
  output logic                        credit_v_o,
  output logic                        drop_v_o,
  output logic [drop_cnt_width_p-1:0] drop_cnt_o
);

  typedef struct packed {
    logic [op_width_gp-1:0]    op;
    logic [addr_width_p-1:0]   addr;
    logic [data_width_p-1:0]   data;
    logic [y_cord_width_p-1:0] from_y;
    logic [x_cord_width_p-1:0] from_x;
    logic [y_cord_width_p-1:0] y;
    logic [x_cord_width_p-1:0] x;
  } packet_s;

  logic                        fifo_v, fifo_yumi;
  logic [packet_width_lp-1:0]  fifo_data;
  packet_s                     head;
  logic                        head_ok, drop_now;
  logic                        credit_r, drop_r;
  logic [drop_cnt_width_p-1:0] drop_cnt_r;
  logic                        unused_src;

  bsg_manycore_pkt_fifo #(
    .width_p (packet_width_lp),
    .els_p   (fifo_els_p)
  ) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .v_o       (fifo_v),
    .data_o    (fifo_data),
    .yumi_i    (fifo_yumi)
  );

  assign head = fifo_data;

  // Source coordinates are carried for the sender's benefit only.
  assign unused_src = ^{head.from_y, head.from_x};

  assign head_ok = is_remote_store(head.op) && (head.x == my_x_i) && (head.y == my_y_i);

  assign v_o    = fifo_v & head_ok;
  assign we_o   = v_o;
  assign addr_o = head.addr;
  assign data_o = head.data;
  assign mask_o = '1;

  // A bad head is discarded immediately; a good head waits for memory.
  assign drop_now  = fifo_v & ~head_ok;
  assign fifo_yumi = drop_now | (v_o & yumi_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credit_r   <= 1'b0;
      drop_r     <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      credit_r <= v_o & yumi_i;
      drop_r   <= drop_now;
      if (drop_now && (drop_cnt_r != {drop_cnt_width_p{1'b1}}))
        drop_cnt_r <= drop_cnt_r + drop_cnt_width_p'(1);
    end
  end

  assign credit_v_o = credit_r;
  assign drop_v_o   = drop_r;
  assign drop_cnt_o = drop_cnt_r;

`ifndef SYNTHESIS
  a_yumi_needs_v : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> v_o)
    else $error("bsg_manycore_pkt_receive: yumi_i asserted while v_o low");

  a_head_stable : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ($past(v_o) && !$past(yumi_i)) |->
      (v_o && (addr_o == $past(addr_o)) && (data_o == $past(data_o))))
    else $error("bsg_manycore_pkt_receive: offered store changed before yumi_i");

  a_input_stable : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ($past(v_i) && !$past(ready_o) && v_i) |-> (data_i == $past(data_i)))
    else $warning("bsg_manycore_pkt_receive: data_i changed while stalled");
`endif

endmodule

// File: tb/tb_bsg_manycore_pkt_receive.sv
module tb_bsg_manycore_pkt_receive;

  localparam int XW = 4, YW = 4, DW = 32, AW = 12;
  localparam int PW = 6 + 2*XW + 2*YW + DW + AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [XW-1:0] my_x = 4'd2;
  logic [YW-1:0] my_y = 4'd3;
  logic          v_in = 1'b0;
  logic [PW-1:0] pkt_in = '0;
  logic          yumi_en = 1'b0;

  logic          ready_o, v_o, we_o, credit_v_o, drop_v_o, yumi;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic [3:0]    mask_o;
  logic [7:0]    drop_cnt_o;

  logic          ready_b, v_b, we_b, credit_b, drop_b, yumi_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] data_b;
  logic [3:0]    mask_b;
  logic [1:0]    drop_cnt_b;

  assign yumi   = yumi_en & v_o;
  assign yumi_b = yumi_en & v_b;

  always #5 clk = ~clk;

  bsg_manycore_pkt_receive #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW), .addr_width_p(AW),
    .fifo_els_p(2), .drop_cnt_width_p(8)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .my_x_i(my_x), .my_y_i(my_y),
    .v_i(v_in), .data_i(pkt_in), .ready_o(ready_o),
    .v_o(v_o), .we_o(we_o), .addr_o(addr_o), .data_o(data_o), .mask_o(mask_o),
    .yumi_i(yumi), .credit_v_o(credit_v_o), .drop_v_o(drop_v_o), .drop_cnt_o(drop_cnt_o)
  );

  // Same stimulus, 2-bit drop counter for saturation.
  bsg_manycore_pkt_receive #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW), .addr_width_p(AW),
    .fifo_els_p(2), .drop_cnt_width_p(2)
  ) dut_sat (
    .clk_i(clk), .reset_n_i(reset_n), .my_x_i(my_x), .my_y_i(my_y),
    .v_i(v_in), .data_i(pkt_in), .ready_o(ready_b),
    .v_o(v_b), .we_o(we_b), .addr_o(addr_b), .data_o(data_b), .mask_o(mask_b),
    .yumi_i(yumi_b), .credit_v_o(credit_b), .drop_v_o(drop_b), .drop_cnt_o(drop_cnt_b)
  );

  typedef struct {
    logic          ok;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic          cur_ok;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic          exp_credit = 1'b0, exp_drop = 1'b0;
  logic [7:0]    exp_cnt = '0;
  logic [1:0]    exp_cnt2 = '0;
  int            nerr = 0, nchk = 0, ncredit = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a clock edge: checks outputs against the model, advances
  // the model for the upcoming edge, then steps one clock.
  task automatic cyc(output logic acc);
    logic nc, nd, ev;
    chk("credit_v_o", credit_v_o, exp_credit);
    chk("drop_v_o", drop_v_o, exp_drop);
    chk("drop_cnt_o", drop_cnt_o, exp_cnt);
    chk("drop_cnt_sat", drop_cnt_b, exp_cnt2);
    if (credit_v_o) ncredit++;
    chk("ready_o", ready_o, sb.size() < 2);
    ev = (sb.size() > 0) && sb[0].ok;
    chk("v_o", v_o, ev);
    chk("we_o", we_o, ev);
    if (ev) begin
      chk("addr_o", addr_o, sb[0].addr);
      chk("data_o", data_o, sb[0].data);
      chk("mask_o", mask_o, 4'hF);
    end
    acc = v_in && (sb.size() < 2);
    nc = 1'b0;
    nd = 1'b0;
    if (sb.size() > 0) begin
      if (!sb[0].ok) begin
        void'(sb.pop_front());
        nd = 1'b1;
        if (exp_cnt != 8'hFF) exp_cnt++;
        if (exp_cnt2 != 2'b11) exp_cnt2++;
      end else if (yumi_en) begin
        void'(sb.pop_front());
        nc = 1'b1;
      end
    end
    if (acc) sb.push_back('{cur_ok, cur_addr, cur_data});
    @(posedge clk);
    #1;
    exp_credit = nc;
    exp_drop   = nd;
  endtask

  task automatic idle(input int n);
    logic acc;
    v_in = 1'b0;
    for (int i = 0; i < n; i++) cyc(acc);
  endtask

  // Presents a packet and holds it until accepted; leaves v_in high.
  task automatic send(input logic [5:0] op, input logic [XW-1:0] x, input logic [YW-1:0] y,
                      input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic acc;
    int   tries;
    pkt_in   = {op, addr, data, 4'h6, 4'h5, y, x};
    v_in     = 1'b1;
    cur_ok   = (op == 6'd1) && (x == 4'd2) && (y == 4'd3);
    cur_addr = addr;
    cur_data = data;
    tries    = 0;
    do begin
      cyc(acc);
      tries++;
    end while (!acc && tries < 20);
    chk("accept_timeout", acc, 1'b1);
  endtask

  // Asserts reset mid-cycle, checks outputs clear at once, releases mid-cycle.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    v_in    = 1'b0;
    #1;
    chk("rst_v_o", v_o, 1'b0);
    chk("rst_credit", credit_v_o, 1'b0);
    chk("rst_drop", drop_v_o, 1'b0);
    chk("rst_drop_cnt", drop_cnt_o, 8'd0);
    chk("rst_drop_cnt_sat", drop_cnt_b, 2'd0);
    sb.delete();
    exp_credit = 1'b0;
    exp_drop   = 1'b0;
    exp_cnt    = '0;
    exp_cnt2   = '0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int c0;

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Reset mid-operation: one drop counted, two stores buffered, then reset.
    yumi_en = 1'b0;
    send(6'd1, 4'd1, 4'd3, 12'h001, 32'h1111_1111);
    send(6'd1, 4'd2, 4'd3, 12'h010, 32'hAAAA_0001);
    send(6'd1, 4'd2, 4'd3, 12'h011, 32'hAAAA_0002);
    idle(2);
    do_reset();
    yumi_en = 1'b1;
    idle(4);

    // Single store: offered next cycle, credit one cycle after yumi.
    send(6'd1, 4'd2, 4'd3, 12'h0A4, 32'hDEAD_BEEF);
    idle(4);

    // Backpressure: third store stalls until memory drains the buffer.
    yumi_en = 1'b0;
    send(6'd1, 4'd2, 4'd3, 12'h100, 32'h0000_0A0A);
    send(6'd1, 4'd2, 4'd3, 12'h101, 32'h0000_0B0B);
    pkt_in = {6'd1, 12'h102, 32'h0000_0C0C, 4'h6, 4'h5, 4'd3, 4'd2};
    idle(0);
    v_in = 1'b1;
    cur_ok = 1'b1; cur_addr = 12'h102; cur_data = 32'h0000_0C0C;
    begin
      logic acc;
      cyc(acc);
      chk("stall_accept", acc, 1'b0);
      cyc(acc);
      chk("stall_accept", acc, 1'b0);
    end
    c0 = ncredit;
    yumi_en = 1'b1;
    send(6'd1, 4'd2, 4'd3, 12'h102, 32'h0000_0C0C);
    idle(5);
    chk("backpressure_credits", ncredit - c0, 3);

    // Misrouted and bad-op drops, then a good store.
    send(6'd1, 4'd1, 4'd3, 12'h200, 32'h0000_0001);
    idle(2);
    send(6'd2, 4'd2, 4'd3, 12'h201, 32'h0000_0002);
    idle(2);
    send(6'd1, 4'd2, 4'd3, 12'h202, 32'h0000_0003);
    idle(3);

    // Saturation: five bad packets back to back.
    do_reset();
    for (int i = 0; i < 5; i++)
      send(6'd1, 4'd2, 4'(4 + i), 12'(i), 32'(i));
    idle(4);
    chk("sat_cnt_final", drop_cnt_b, 2'd3);
    chk("wide_cnt_final", drop_cnt_o, 8'd5);

    // Streaming: 16 stores with v_i and yumi held high.
    c0 = ncredit;
    for (int i = 0; i < 16; i++)
      send(6'd1, 4'd2, 4'd3, 12'(12'h300 + i), $urandom);
    idle(4);
    chk("stream_credits", ncredit - c0, 16);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
